sram_like_responder: RTL

- Memory-side responder for the CPU core's SRAM-like data interface; the slave end of the bus the datapath's memory stage drives.
- Accepts read and write requests on an addr_ok/data_ok handshake and services them from an internal word array.
- Returns responses strictly in order after a programmable latency.
- Serves as the simulation and FPGA-bringup data memory behind the SoC SRAM top, and as the checker target for the load/store byte-select logic.

---
 rtl/sram_like_pkg.sv | 36 +++
 rtl/resp_queue.sv | 67 ++++++
 rtl/sram_like_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like data-memory responder: access-size codes,
// the response-queue entry layout and the misalignment rule.
package sram_like_pkg;

  localparam int LAT_W     = 4;   // countdown width; LATENCY is 1..15
  localparam int IDX_MAX_W = 30;  // widest word index a 32-bit byte address can carry

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // One accepted request waiting for its response slot. The word index is
  // stored zero-extended to IDX_MAX_W; the top only uses its low ADDR_W bits.
  typedef struct packed {
    logic                 wr;
    logic [1:0]           size;
    logic [IDX_MAX_W-1:0] idx;
    logic [3:0]           wstrb;
    logic [31:0]          wdata;
    logic                 mis;
    logic [LAT_W-1:0]     cnt;
  } queueEntry_t;

  // Halfwords need bit 0 clear, words (and the reserved code 3) need both
  // low bits clear; bytes are always aligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    if (size == SZ_BYTE)      mis = 1'b0;
    else if (size == SZ_HALF) mis = offset[0];
    else                      mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/resp_queue.sv
// In-order response queue: a DEPTH-entry circular buffer where every valid
// entry counts down towards zero; the head retires once its count hits zero.
module resp_queue
  import sram_like_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  queueEntry_t       pushEntry,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output queueEntry_t       headEntry,
  output logic              headReady
);

  queueEntry_t      entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy bookkeeping: pointers, per-slot valid flags and the entry count.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      headPtr <= '0;
      tailPtr <= '0;
      valid   <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        valid[tailPtr] <= 1'b1;
        tailPtr        <= nextPtr(tailPtr);
      end
      if (pop) begin
        valid[headPtr] <= 1'b0;
        headPtr        <= nextPtr(headPtr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry payloads: load on push, otherwise tick the countdown of live entries.
  // NOTE: payload storage has no reset; only the valid flags are cleared, and
  // an invalid slot's contents are never looked at.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && tailPtr == PTR_W'(i)) begin
        entries[i] <= pushEntry;
      end else if (valid[i] && entries[i].cnt != '0) begin
        entries[i].cnt <= entries[i].cnt - 1'b1;
      end
    end
  end

  assign headEntry = entries[headPtr];
  assign headReady = valid[headPtr] && (headEntry.cnt == '0);

endmodule

// File: rtl/sram_like_responder.sv
// Data-memory slave for the core's SRAM-like bus: accepts reads/writes on an
// addr_ok/data_ok handshake, answers them in order after LATENCY cycles, and
// performs the actual memory access at retire time so ordering is preserved.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]       mem [2**ADDR_W];
  logic [CNT_W-1:0]  count;
  queueEntry_t       pushEntry;
  queueEntry_t       headEntry;
  logic              headReady;
  logic              accept;
  logic [ADDR_W-1:0] headIdx;
  logic              unusedBits;

  // A full queue never accepts, even if the head retires this cycle.
  assign addr_ok = resetn && (count < CNT_W'(DEPTH));
  assign accept  = req && addr_ok;
  assign headIdx = headEntry.idx[ADDR_W-1:0];

  // Build the queue entry for the request presented this cycle.
  always_comb begin
    pushEntry       = '0;
    pushEntry.wr    = wr;
    pushEntry.size  = size;
    pushEntry.idx   = IDX_MAX_W'(addr[ADDR_W+1:2]);
    pushEntry.wstrb = wstrb;
    pushEntry.wdata = wdata;
    pushEntry.mis   = isMisaligned(size, addr[1:0]);
    pushEntry.cnt   = LAT_W'(LATENCY - 1);
  end

  resp_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .pushEntry (pushEntry),
    .pop       (headReady),
    .count     (count),
    .headEntry (headEntry),
    .headReady (headReady)
  );

  // Response outputs come from the queue head and the array only.
  // NOTE: every output gets a default before the branches so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    data_ok = headReady;
    err     = 1'b0;
    rdata   = '0;
    if (headReady) begin
      if (headEntry.mis)    err   = 1'b1;
      else if (!headEntry.wr) rdata = mem[headIdx];
    end
  end

  // Commit an aligned write's enabled byte lanes as its response retires;
  // the array is deliberately left untouched by resetn.
  always_ff @(posedge clk) begin
    if (headReady && headEntry.wr && !headEntry.mis) begin
      for (int b = 0; b < 4; b++) begin
        if (headEntry.wstrb[b]) mem[headIdx][8*b +: 8] <= headEntry.wdata[8*b +: 8];
      end
    end
  end

  // Address bits above the array and head fields not needed at retire.
  assign unusedBits = ^{addr[31:ADDR_W+2], headEntry.size,
                        headEntry.idx[IDX_MAX_W-1:ADDR_W], headEntry.cnt};

endmodule
